div_tick_gen: RTL and testbench

//   Consumer stage for the divider outputs (divideby2/4/8/16 bus). Samples the taps in the clk

---
 rtl/div_tick_gen.sv | 137 +++++++++++++
 tb/tb_div_tick_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_tick_gen.sv
// div_tick_gen: turns rising edges of a selected divider tap into one-cycle
// tick enables on clk. It supports tap switching at a period boundary, keeps
// a wrapping tick counter, and flags a dead tap with a watchdog.
//
// state | meaning
// RUN   | ticks from active_sel, no switch requested
// PEND  | switch to pend_sel requested; ticks continue on the old tap until its next rise
module div_tick_gen #(
  parameter int NUM_TAPS = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16,
  parameter int WD_LIMIT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_TAPS-1:0] div_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_load,
  input  logic                cnt_clr,
  output logic                tick,
  output logic [CNT_W-1:0]    tick_cnt,
  output logic [SEL_W-1:0]    active_sel,
  output logic                switching,
  output logic                stall
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int WD_W  = $clog2(WD_LIMIT + 1);
  localparam logic [SEL_W:0]   TAPS_LIM = (SEL_W+1)'(NUM_TAPS);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(WD_LIMIT);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [NUM_TAPS-1:0] div_q;
  logic                armed;
  logic [SEL_W-1:0]    pend_sel, pend_sel_nxt, active_sel_nxt;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic [IDX_W-1:0]    act_idx;
  logic                tap_edge;
  logic                sel_ok;
  logic                complete;

  // Active tap index, trimmed to the width needed to address div_in.
  assign act_idx  = active_sel[IDX_W-1:0];
  // armed masks the first cycle after reset so a tap already high is not taken as a rise.
  assign tap_edge = armed & div_in[act_idx] & ~div_q[act_idx];
  assign sel_ok   = sel_load & ({1'b0, sel} < TAPS_LIM);
  assign switching = (state == PEND);

  // Next-state logic; a cancelling reload takes priority over a completing edge.
  always_comb begin
    state_nxt      = state;
    pend_sel_nxt   = pend_sel;
    active_sel_nxt = active_sel;
    complete       = 1'b0;
    case (state)
      RUN: begin
        if (sel_ok && (sel != active_sel)) begin
          pend_sel_nxt = sel;
          state_nxt    = PEND;
        end
      end
      PEND: begin
        if (sel_ok && (sel == active_sel)) begin
          state_nxt = RUN;
        end else begin
          if (sel_ok) pend_sel_nxt = sel;
          if (tap_edge) begin
            active_sel_nxt = pend_sel_nxt;
            state_nxt      = RUN;
            complete       = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Watchdog next value: restart on a tick edge, otherwise count up and saturate.
  always_comb begin
    wd_nxt = wd_cnt;
    if (tap_edge || complete) begin
      wd_nxt = '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_nxt = wd_cnt + WD_W'(1);
    end
  end

  // Tap switching FSM and selection registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pend_sel   <= '0;
      active_sel <= '0;
    end else begin
      state      <= state_nxt;
      pend_sel   <= pend_sel_nxt;
      active_sel <= active_sel_nxt;
    end
  end

  // Tap sampling, tick generation and tick counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      armed    <= 1'b0;
      tick     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      div_q <= div_in;
      armed <= 1'b1;
      tick  <= tap_edge;
      if (cnt_clr) begin
        tick_cnt <= '0;
      end else if (tap_edge) begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end

  // Watchdog counter and sticky stall flag, cleared as the next tick issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      stall  <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      if (tap_edge) begin
        stall <= 1'b0;
      end else if (wd_nxt == WD_MAX) begin
        stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_tick_gen.sv
// Testbench for div_tick_gen: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model held in the bench.
module tb_div_tick_gen;

  localparam int NUM_TAPS = 4;
  localparam int SEL_W    = 3;
  localparam int CNT_W    = 4;
  localparam int WD_LIMIT = 32;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_TAPS-1:0] div_in;
  logic [SEL_W-1:0]    sel;
  logic                sel_load;
  logic                cnt_clr;
  logic                tick;
  logic [CNT_W-1:0]    tick_cnt;
  logic [SEL_W-1:0]    active_sel;
  logic                switching;
  logic                stall;

  int checks = 0;
  int errors = 0;

  // Stimulus source: free-running ripple divider, optionally forced silent.
  int unsigned ctr = 0;
  bit          force_off = 1'b0;

  // Reference model state.
  logic [NUM_TAPS-1:0] m_prev;
  bit m_armed, m_pending, m_tick, m_stall;
  int m_active, m_pend, m_cnt, m_wd;

  div_tick_gen #(
    .NUM_TAPS(NUM_TAPS), .SEL_W(SEL_W), .CNT_W(CNT_W), .WD_LIMIT(WD_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .sel(sel), .sel_load(sel_load),
    .cnt_clr(cnt_clr), .tick(tick), .tick_cnt(tick_cnt), .active_sel(active_sel),
    .switching(switching), .stall(stall)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    m_prev = '0; m_armed = 0; m_pending = 0; m_tick = 0; m_stall = 0;
    m_active = 0; m_pend = 0; m_cnt = 0; m_wd = 0;
  endtask

  // One clock of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit rise, valid;
    if (!rst) begin
      model_reset();
      return;
    end
    rise  = m_armed && div_in[m_active] && !m_prev[m_active];
    valid = sel_load && (int'(sel) < NUM_TAPS);
    m_tick = rise;
    if (cnt_clr) m_cnt = 0;
    else if (rise) m_cnt = (m_cnt + 1) % CNT_MOD;
    if (!m_pending) begin
      if (valid && int'(sel) != m_active) begin
        m_pending = 1; m_pend = int'(sel);
      end
    end else if (valid && int'(sel) == m_active) begin
      m_pending = 0;
    end else begin
      if (valid) m_pend = int'(sel);
      if (rise) begin
        m_active = m_pend; m_pending = 0;
      end
    end
    if (rise) m_wd = 0;
    else if (m_wd < WD_LIMIT) m_wd++;
    if (rise) m_stall = 0;
    else if (m_wd == WD_LIMIT) m_stall = 1;
    m_prev  = div_in;
    m_armed = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("tick_cnt", 32'(tick_cnt), 32'(m_cnt));
    chk("active_sel", 32'(active_sel), 32'(m_active));
    chk("switching", 32'(switching), 32'(m_pending));
    chk("stall", 32'(stall), 32'(m_stall));
  endtask

  task automatic drive_div();
    ctr++;
    div_in = force_off ? '0 : ctr[NUM_TAPS-1:0];
  endtask

  // One clock: model update, check outputs 1ns after the edge, advance divider.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    drive_div();
  endtask

  initial begin
    int k;
    rst = 1'b0; sel = '0; sel_load = 1'b0; cnt_clr = 1'b0; div_in = '0;
    model_reset();

    // T1: reset then free-running div2 ticks
    repeat (3) cyc();
    rst = 1'b1;
    repeat (12) cyc();

    // T2: switch to div16 mid-period
    sel = 3'd3; sel_load = 1'b1; cyc(); sel_load = 1'b0;
    repeat (40) cyc();
    chk("t2_active", 32'(active_sel), 32'd3);

    // T3: retarget while pending, cancel, out-of-range ignored
    sel = 3'd0; sel_load = 1'b1; cyc(); sel_load = 1'b0;
    repeat (20) cyc();
    sel = 3'd3; sel_load = 1'b1; cyc();
    sel = 3'd1; cyc(); sel_load = 1'b0;
    repeat (20) cyc();
    chk("t3_retarget", 32'(active_sel), 32'd1);
    sel = 3'd3; sel_load = 1'b1; cyc();
    sel = 3'd1; cyc(); sel_load = 1'b0;
    chk("t3_cancel", 32'(switching), 32'd0);
    sel = 3'd5; sel_load = 1'b1; cyc(); sel_load = 1'b0;
    chk("t3_oor", 32'(switching), 32'd0);
    repeat (4) cyc();

    // T4: silence the divider right after a tick; watchdog fires 32 clocks later
    k = 0;
    while (!m_tick && k < 20) begin cyc(); k++; end
    chk("t4_tick_seen", 32'(m_tick), 32'd1);
    force_off = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == WD_LIMIT - 1) chk("t4_stall_early", 32'(stall), 32'd0);
      if (i == WD_LIMIT) chk("t4_stall_on", 32'(stall), 32'd1);
    end
    chk("t4_stall_sticky", 32'(stall), 32'd1);
    force_off = 1'b0;
    k = 0;
    while (!m_tick && k < 20) begin cyc(); k++; end
    chk("t4_stall_clear", 32'(stall), 32'd0);

    // T5: counter wrap on div2 and clear coincident with a tick
    sel = 3'd0; sel_load = 1'b1; cyc(); sel_load = 1'b0;
    repeat (40) cyc();
    cnt_clr = 1'b1; cyc(); cyc(); cnt_clr = 1'b0;
    chk("t5_clr", 32'(tick_cnt), 32'd0);
    repeat (6) cyc();

    // T6: asynchronous reset while a switch is pending
    sel = 3'd3; sel_load = 1'b1; cyc(); sel_load = 1'b0;
    chk("t6_pending", 32'(switching), 32'd1);
    #4 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_tick", 32'(tick), 32'd0);
    chk("t6_switching", 32'(switching), 32'd0);
    chk("t6_cnt", 32'(tick_cnt), 32'd0);
    chk("t6_active", 32'(active_sel), 32'd0);
    chk("t6_stall", 32'(stall), 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (4) cyc();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      sel      = SEL_W'($urandom_range(7, 0));
      sel_load = ($urandom_range(5, 0) == 0);
      cnt_clr  = ($urandom_range(24, 0) == 0);
      if ($urandom_range(59, 0) == 0) force_off = ~force_off;
      rst      = ($urandom_range(199, 0) != 0);
      cyc();
    end
    sel_load = 1'b0; cnt_clr = 1'b0; force_off = 1'b0; rst = 1'b1;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
